// File: rtl/tlb_refill_arbiter_pkg.sv
// Shared definitions for the JTLB refill arbiter: entry layout and FSM states.
package tlb_refill_arbiter_pkg;

  localparam int unsigned VPN2_W = 19;
  localparam int unsigned REQ_I  = 0;
  localparam int unsigned REQ_D  = 1;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [7:0]        asid;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOOKUP = 2'd1,
    ARB_WRITE  = 2'd2,
    ARB_FENCE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/tlb_refill_arbiter_if.sv
// Bundle of L1 TLB refill, JTLB search/write and CP0 write handshake signals.
interface tlb_refill_arbiter_if;
  import tlb_refill_arbiter_pkg::*;

  logic              itlb_req;
  logic [VPN2_W-1:0] itlb_vpn2;
  logic              itlb_resp;
  logic              itlb_found;
  tlb_entry_t        itlb_entry;

  logic              dtlb_req;
  logic [VPN2_W-1:0] dtlb_vpn2;
  logic              dtlb_resp;
  logic              dtlb_found;
  tlb_entry_t        dtlb_entry;

  logic [VPN2_W-1:0] jtlb_vpn2;
  logic              jtlb_found;
  tlb_entry_t        jtlb_entry;

  logic              tlbw_req;
  logic              jtlb_we;
  logic              tlbw_done;
  logic              fence_tlb;

  // Arbiter side
  modport slave (
    input  itlb_req, itlb_vpn2, dtlb_req, dtlb_vpn2,
    input  jtlb_found, jtlb_entry, tlbw_req,
    output itlb_resp, itlb_found, itlb_entry,
    output dtlb_resp, dtlb_found, dtlb_entry,
    output jtlb_vpn2, jtlb_we, tlbw_done, fence_tlb
  );

  // Environment side (L1 TLBs, CP0, JTLB array)
  modport master (
    output itlb_req, itlb_vpn2, dtlb_req, dtlb_vpn2,
    output jtlb_found, jtlb_entry, tlbw_req,
    input  itlb_resp, itlb_found, itlb_entry,
    input  dtlb_resp, dtlb_found, dtlb_entry,
    input  jtlb_vpn2, jtlb_we, tlbw_done, fence_tlb
  );

endinterface

// File: rtl/tlb_refill_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the I-TLB, bit 1 the D-TLB.
module rr_arb2
  import tlb_refill_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] elig_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic       prio_d_q;
  logic [1:0] cand;

  // One-hot grant among eligible requesters, ties broken by prio_d_q
  always_comb begin
    cand  = req_i & elig_i;
    gnt_o = cand;
    if (&cand) begin
      gnt_o = prio_d_q ? 2'b10 : 2'b01;
    end
  end

  // Favour the other side after each accepted grant
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_d_q <= 1'b1;
    end else if (adv_i && (|gnt_o)) begin
      prio_d_q <= gnt_o[REQ_I];
    end
  end

endmodule

// File: rtl/tlb_refill_arbiter.sv
// Shares the JTLB search port between I/D refill engines and serialises CP0 writes.
module tlb_refill_arbiter
  import tlb_refill_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  tlb_refill_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [VPN2_W-1:0] vpn_q, vpn_d;
  logic              i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic              i_found_q, i_found_d, d_found_q, d_found_d;
  tlb_entry_t        i_entry_q, i_entry_d, d_entry_q, d_entry_d;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              we;
  logic              fence;

  // Requesters whose response is on the wire this cycle are masked off
  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({bus.dtlb_req, bus.itlb_req}),
    .elig_i (~{d_resp_q, i_resp_q}),
    .adv_i  (grant_en),
    .gnt_o  (gnt)
  );

  // Next-state and strobe decode; writes take priority over lookups in IDLE
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    we       = 1'b0;
    fence    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (bus.tlbw_req) begin
          state_d = ARB_WRITE;
        end else if (|gnt) begin
          grant_en = 1'b1;
          state_d  = ARB_LOOKUP;
        end
      end
      ARB_LOOKUP: state_d = ARB_IDLE;
      ARB_WRITE: begin
        we      = 1'b1;
        state_d = ARB_FENCE;
      end
      ARB_FENCE: begin
        fence   = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Search key/owner capture on grant; owner's response captured in LOOKUP
  always_comb begin
    owner_d   = owner_q;
    vpn_d     = vpn_q;
    if (grant_en) begin
      owner_d = gnt[REQ_D] ? OWN_D : OWN_I;
      vpn_d   = gnt[REQ_D] ? bus.dtlb_vpn2 : bus.itlb_vpn2;
    end
    i_resp_d  = (state_q == ARB_LOOKUP) && (owner_q == OWN_I);
    d_resp_d  = (state_q == ARB_LOOKUP) && (owner_q == OWN_D);
    i_found_d = i_resp_d ? bus.jtlb_found : i_found_q;
    i_entry_d = i_resp_d ? bus.jtlb_entry : i_entry_q;
    d_found_d = d_resp_d ? bus.jtlb_found : d_found_q;
    d_entry_d = d_resp_d ? bus.jtlb_entry : d_entry_q;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      vpn_q     <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_found_q <= 1'b0;
      d_found_q <= 1'b0;
      i_entry_q <= '0;
      d_entry_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      vpn_q     <= vpn_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      i_found_q <= i_found_d;
      d_found_q <= d_found_d;
      i_entry_q <= i_entry_d;
      d_entry_q <= d_entry_d;
    end
  end

  assign bus.itlb_resp  = i_resp_q;
  assign bus.itlb_found = i_found_q;
  assign bus.itlb_entry = i_entry_q;
  assign bus.dtlb_resp  = d_resp_q;
  assign bus.dtlb_found = d_found_q;
  assign bus.dtlb_entry = d_entry_q;
  assign bus.jtlb_vpn2  = vpn_q;
  assign bus.jtlb_we    = we;
  assign bus.tlbw_done  = fence;
  assign bus.fence_tlb  = fence;

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// event-scheduling reference model of the arbiter.
module tb_tlb_refill_arbiter;
  import tlb_refill_arbiter_pkg::*;

  localparam int unsigned MAXC = 4096;
  localparam int unsigned JT_N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_refill_arbiter_if bus();

  tlb_refill_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic       found;
    tlb_entry_t e;
  } hit_t;

  // JTLB array model (environment)
  tlb_entry_t  jt   [JT_N];
  logic        jt_v [JT_N];
  int unsigned jt_gen = 0;
  hit_t        env_hit;

  function automatic hit_t jt_lookup(logic [18:0] v);
    hit_t h;
    h = '0;
    for (int k = JT_N - 1; k >= 0; k--) begin
      if (jt_v[k] && jt[k].vpn2 == v) begin
        h.found = 1'b1;
        h.e     = jt[k];
      end
    end
    return h;
  endfunction

  always @(bus.jtlb_vpn2 or jt_gen) begin
    env_hit        = jt_lookup(bus.jtlb_vpn2);
    bus.jtlb_found = env_hit.found;
    bus.jtlb_entry = env_hit.e;
  end

  function automatic tlb_entry_t rand_entry(logic [18:0] v);
    tlb_entry_t e;
    e      = '0;
    e.vpn2 = v;
    e.asid = 8'($urandom);
    e.g    = 1'($urandom);
    e.pfn0 = 20'($urandom);
    e.c0   = 3'($urandom);
    e.d0   = 1'($urandom);
    e.v0   = 1'b1;
    e.pfn1 = 20'($urandom);
    e.c1   = 3'($urandom);
    e.d1   = 1'($urandom);
    e.v1   = 1'($urandom);
    return e;
  endfunction

  // Checking
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: schedules expected output events into per-cycle tables
  bit          e_iresp [MAXC];
  bit          e_dresp [MAXC];
  bit          e_we    [MAXC];
  bit          e_fd    [MAXC];
  bit          e_vset  [MAXC];
  logic [18:0] e_vval  [MAXC];
  logic        e_ifnd  [MAXC];
  logic        e_dfnd  [MAXC];
  tlb_entry_t  e_ient  [MAXC];
  tlb_entry_t  e_dent  [MAXC];

  int unsigned t;
  int unsigned m_free;
  bit          m_prio_d;
  logic [18:0] m_vpn;
  logic        m_ifound, m_dfound;
  tlb_entry_t  m_ient, m_dent;

  // Stimulus agents
  bit          rnd_mode = 0;
  bit          i_hold   = 0;
  bit          d_hold   = 0;
  int unsigned pend_idx = 0;
  tlb_entry_t  pend_e   = '0;

  task automatic model_clear();
    for (int unsigned k = 0; k < MAXC; k++) begin
      e_iresp[k] = 0; e_dresp[k] = 0; e_we[k] = 0; e_fd[k] = 0; e_vset[k] = 0;
      e_vval[k] = '0; e_ifnd[k] = 0; e_dfnd[k] = 0; e_ient[k] = '0; e_dent[k] = '0;
    end
    m_free   = 0;
    m_prio_d = 1;
    m_vpn    = '0;
    m_ifound = 0;
    m_dfound = 0;
    m_ient   = '0;
    m_dent   = '0;
  endtask

  task automatic apply_check();
    if (e_vset[t]) m_vpn = e_vval[t];
    if (e_iresp[t]) begin m_ifound = e_ifnd[t]; m_ient = e_ient[t]; end
    if (e_dresp[t]) begin m_dfound = e_dfnd[t]; m_dent = e_dent[t]; end
    check("itlb_resp",  bus.itlb_resp,  e_iresp[t]);
    check("itlb_found", bus.itlb_found, m_ifound);
    check("itlb_entry", bus.itlb_entry, m_ient);
    check("dtlb_resp",  bus.dtlb_resp,  e_dresp[t]);
    check("dtlb_found", bus.dtlb_found, m_dfound);
    check("dtlb_entry", bus.dtlb_entry, m_dent);
    check("jtlb_vpn2",  bus.jtlb_vpn2,  m_vpn);
    check("jtlb_we",    bus.jtlb_we,    e_we[t]);
    check("fence_tlb",  bus.fence_tlb,  e_fd[t]);
    check("tlbw_done",  bus.tlbw_done,  e_fd[t]);
  endtask

  // Arbitration decision for cycle t from the inputs currently driven
  task automatic decide();
    bit   ei, ed, side_d;
    hit_t h;
    logic [18:0] v;
    if (t < m_free) return;
    if (bus.tlbw_req) begin
      e_we[t+1] = 1;
      e_fd[t+2] = 1;
      m_free    = t + 3;
      return;
    end
    ei = bus.itlb_req && !e_iresp[t];
    ed = bus.dtlb_req && !e_dresp[t];
    if (!(ei || ed)) return;
    side_d = ed && (!ei || m_prio_d);
    v = side_d ? bus.dtlb_vpn2 : bus.itlb_vpn2;
    h = jt_lookup(v);
    e_vset[t+1] = 1;
    e_vval[t+1] = v;
    if (side_d) begin
      e_dresp[t+2] = 1; e_dfnd[t+2] = h.found; e_dent[t+2] = h.e;
    end else begin
      e_iresp[t+2] = 1; e_ifnd[t+2] = h.found; e_ient[t+2] = h.e;
    end
    m_free   = t + 2;
    m_prio_d = !side_d;
  endtask

  // Environment reaction: JTLB write, requesters and CP0
  task automatic env_step();
    if (bus.jtlb_we) begin
      jt[pend_idx]   = pend_e;
      jt_v[pend_idx] = 1'b1;
      jt_gen++;
    end
    if (bus.itlb_resp && !(i_hold || (rnd_mode && $urandom_range(0, 1) == 1))) bus.itlb_req = 1'b0;
    if (bus.dtlb_resp && !(d_hold || (rnd_mode && $urandom_range(0, 1) == 1))) bus.dtlb_req = 1'b0;
    if (bus.tlbw_done) bus.tlbw_req = 1'b0;
    if (rnd_mode) begin
      if (!bus.itlb_req && $urandom_range(0, 3) == 0) begin
        bus.itlb_vpn2 = 19'($urandom_range(0, 15));
        bus.itlb_req  = 1'b1;
      end
      if (!bus.dtlb_req && $urandom_range(0, 3) == 0) begin
        bus.dtlb_vpn2 = 19'($urandom_range(0, 15));
        bus.dtlb_req  = 1'b1;
      end
      if (!bus.tlbw_req && !bus.tlbw_done && $urandom_range(0, 15) == 0) begin
        pend_idx     = $urandom_range(0, JT_N - 1);
        pend_e       = rand_entry(19'($urandom_range(0, 15)));
        bus.tlbw_req = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    env_step();
    decide();
    @(posedge clk);
    @(negedge clk);
    t++;
    apply_check();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.itlb_req = 1'b0;
    bus.dtlb_req = 1'b0;
    bus.tlbw_req = 1'b0;
    i_hold       = 0;
    d_hold       = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    t = 0;
    apply_check();
  endtask

  initial begin
    bus.itlb_req  = 1'b0;
    bus.dtlb_req  = 1'b0;
    bus.tlbw_req  = 1'b0;
    bus.itlb_vpn2 = '0;
    bus.dtlb_vpn2 = '0;
    for (int unsigned k = 0; k < JT_N; k++) begin
      jt[k]   = rand_entry(19'($urandom_range(0, 15)));
      jt_v[k] = 1'($urandom);
    end
    jt[0]      = rand_entry(19'h00012);
    jt[0].pfn0 = 20'h0ABCD;
    jt_v[0]    = 1'b1;
    jt_gen++;
    @(negedge clk);

    // Single D lookup
    do_reset();
    bus.dtlb_vpn2 = 19'h00012;
    bus.dtlb_req  = 1'b1;
    cyc();
    check("t1_jtlb_vpn2", bus.jtlb_vpn2, 19'h00012);
    cyc();
    check("t1_dtlb_resp",  bus.dtlb_resp, 1'b1);
    check("t1_dtlb_found", bus.dtlb_found, 1'b1);
    check("t1_dtlb_pfn0",  bus.dtlb_entry.pfn0, 20'h0ABCD);
    check("t1_itlb_resp",  bus.itlb_resp, 1'b0);
    repeat (3) cyc();

    // Tie and round-robin: D, I, D, I at cycles 2, 4, 6, 8
    do_reset();
    i_hold = 1; d_hold = 1;
    bus.itlb_vpn2 = 19'h00003;
    bus.dtlb_vpn2 = 19'h00012;
    bus.itlb_req  = 1'b1;
    bus.dtlb_req  = 1'b1;
    for (int unsigned c = 1; c <= 8; c++) begin
      cyc();
      if (c % 2 == 0) begin
        check("t2_dtlb_resp", bus.dtlb_resp, 1'((c % 4) == 2));
        check("t2_itlb_resp", bus.itlb_resp, 1'((c % 4) == 0));
      end
    end
    i_hold = 0; d_hold = 0;
    repeat (5) cyc();

    // Miss
    do_reset();
    bus.itlb_vpn2 = 19'h7FFFF;
    bus.itlb_req  = 1'b1;
    cyc(); cyc();
    check("t3_itlb_resp",  bus.itlb_resp, 1'b1);
    check("t3_itlb_found", bus.itlb_found, 1'b0);
    repeat (2) cyc();

    // Write beats a simultaneous lookup; lookup sees the new entry
    do_reset();
    pend_idx      = 5;
    pend_e        = rand_entry(19'h00055);
    pend_e.pfn0   = 20'h01234;
    bus.tlbw_req  = 1'b1;
    bus.dtlb_vpn2 = 19'h00055;
    bus.dtlb_req  = 1'b1;
    cyc();
    check("t4_jtlb_we", bus.jtlb_we, 1'b1);
    cyc();
    check("t4_fence_tlb", bus.fence_tlb, 1'b1);
    check("t4_tlbw_done", bus.tlbw_done, 1'b1);
    cyc(); cyc();
    check("t4_jtlb_vpn2", bus.jtlb_vpn2, 19'h00055);
    cyc();
    check("t4_dtlb_resp",  bus.dtlb_resp, 1'b1);
    check("t4_dtlb_found", bus.dtlb_found, 1'b1);
    check("t4_dtlb_pfn0",  bus.dtlb_entry.pfn0, 20'h01234);
    repeat (2) cyc();

    // Write raised during LOOKUP waits for the response
    do_reset();
    bus.dtlb_vpn2 = 19'h00012;
    bus.dtlb_req  = 1'b1;
    cyc();
    pend_idx      = 6;
    pend_e        = rand_entry(19'h00066);
    bus.tlbw_req  = 1'b1;
    bus.itlb_vpn2 = 19'h00004;
    bus.itlb_req  = 1'b1;
    cyc();
    check("t5_dtlb_resp", bus.dtlb_resp, 1'b1);
    check("t5_jtlb_we_c2", bus.jtlb_we, 1'b0);
    cyc();
    check("t5_jtlb_we_c3", bus.jtlb_we, 1'b1);
    check("t5_vpn_write", bus.jtlb_vpn2, 19'h00012);
    cyc();
    check("t5_fence_tlb", bus.fence_tlb, 1'b1);
    check("t5_vpn_fence", bus.jtlb_vpn2, 19'h00012);
    cyc(); cyc();
    check("t5_vpn_lookup", bus.jtlb_vpn2, 19'h00004);
    cyc();
    check("t5_itlb_resp", bus.itlb_resp, 1'b1);
    repeat (2) cyc();

    // Reset in LOOKUP: no response, priority back to D
    do_reset();
    bus.dtlb_vpn2 = 19'h00012;
    bus.dtlb_req  = 1'b1;
    cyc();
    do_reset();
    check("t6_dtlb_resp", bus.dtlb_resp, 1'b0);
    check("t6_jtlb_vpn2", bus.jtlb_vpn2, 19'h00000);
    bus.itlb_vpn2 = 19'h00003;
    bus.dtlb_vpn2 = 19'h00012;
    bus.itlb_req  = 1'b1;
    bus.dtlb_req  = 1'b1;
    cyc(); cyc();
    check("t6_dtlb_first", bus.dtlb_resp, 1'b1);
    check("t6_itlb_wait",  bus.itlb_resp, 1'b0);
    repeat (4) cyc();

    // Randomized traffic with occasional resets
    do_reset();
    rnd_mode = 1;
    for (int unsigned n = 0; n < 6000; n++) begin
      if (t > MAXC - 16 || $urandom_range(0, 499) == 0) do_reset();
      else cyc();
    end
    rnd_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_refill_arbiter.md
# tlb_refill_arbiter

- Shares the single JTLB (L2 TLB) search port between the L1 I-TLB and L1 D-TLB refill engines.
- Serialises those searches against CP0-initiated JTLB writes (TLBWI/TLBWR).
- After every JTLB write, broadcasts a fence so both L1 TLBs invalidate their contents.
- Sits between the two L1 TLBs, CP0 and the JTLB array.

## Interface

Parameters: none. VPN2 width is fixed at 19 bits ([31:13]).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- itlb_req  in  1  I-TLB refill request; held high until itlb_resp
- itlb_vpn2  in  19  I-TLB VPN2; stable while itlb_req is high
- itlb_resp  out  1  one-cycle pulse, response valid
- itlb_found  out  1  JTLB hit, valid with itlb_resp
- itlb_entry  out  tlb_entry  matched entry, valid with itlb_resp
- dtlb_req, dtlb_vpn2, dtlb_resp, dtlb_found, dtlb_entry  same as the I-TLB ports, for the D-TLB
- jtlb_vpn2  out  19  registered search key to the JTLB
- jtlb_found  in  1  JTLB combinational hit for jtlb_vpn2
- jtlb_entry  in  tlb_entry  JTLB combinational match result
- tlbw_req  in  1  CP0 TLB write request; held until tlbw_done
- jtlb_we  out  1  one-cycle JTLB write strobe (CP0 supplies index and data)
- tlbw_done  out  1  one-cycle pulse, write completed
- fence_tlb  out  1  one-cycle pulse, L1 TLBs invalidate all entries

## Operation

States: IDLE, LOOKUP, WRITE, FENCE.

IDLE:
- Priority order: tlbw_req first, then lookups.
- tlbw_req -> WRITE.
- Otherwise, eligible requesters are those with req high and resp not asserted this cycle. This mask prevents re-granting a requester in the same cycle its response is delivered.
- One eligible requester: grant it.
- Both eligible: grant per the round-robin bit prio_d. prio_d=1 favours D.
- On grant:
  - jtlb_vpn2 <= granted vpn2.
  - owner <= grantee.
  - prio_d <= (grantee == I).
  - next state LOOKUP.

LOOKUP:
- Sample jtlb_found and jtlb_entry into the owner's response registers.
- Pulse the owner's resp in the next cycle.
- Return to IDLE.
- A tlbw_req arriving in LOOKUP waits for IDLE.

WRITE:
- jtlb_we=1 for exactly this cycle.
- Next state FENCE.

FENCE:
- fence_tlb=1 and tlbw_done=1 for this cycle.
- Next state IDLE.

General rules:
- Lookups are never granted in WRITE or FENCE, so no search observes a half-written JTLB.
- The non-owner's resp never pulses. Its found/entry outputs hold their last values.
- A requester dropping req before its resp is illegal. The arbiter still completes the lookup and pulses resp.

## Timing

Reset values:
- State IDLE, prio_d=1.
- All resp, found, jtlb_we, tlbw_done and fence_tlb outputs 0.
- jtlb_vpn2 and the *_entry outputs are 0.

Lookup latency:
- Request seen in IDLE at cycle 0.
- LOOKUP at cycle 1.
- resp, found and entry visible at cycle 2.
- Back-to-back grants: the second grant can occur at cycle 2, its LOOKUP at cycle 3, for a throughput of one lookup per two cycles.

Write latency:
- tlbw_req in IDLE at cycle 0.
- jtlb_we at cycle 1.
- fence_tlb and tlbw_done at cycle 2.
- Lookups resume at cycle 3.

Simultaneous events:
- Simultaneous tlbw_req and lookup requests in IDLE: the write wins. The lookups are granted after FENCE and see the new JTLB contents.
- Reset mid-operation: an in-flight LOOKUP is abandoned and no resp pulses. An in-flight WRITE/FENCE is abandoned, with no fence or done pulses after reset.
- jtlb_vpn2 only changes on a grant.

## Structure

- The tlb_entry typedef (VPN2, ASID, G, PFN0/1, C0/1, D0/1, V0/1) lives in the shared defines package.
- The arbiter state enum also lives in that package, for waveform decode.
- One sub-module, rr_arb2: a two-requester round-robin arbiter.
  - Inputs: req[1:0], eligibility mask, advance strobe.
  - Outputs: one-hot grant, with prio_d held internally.
- The FSM, response registers and write sequencing stay in the top module.

## Test plan

1. Single D lookup:
   - Stimulus: dtlb_req, vpn2=19'h00012; JTLB returns found=1, PFN0=20'h0ABCD.
   - Required: jtlb_vpn2=19'h00012 at cycle 1; dtlb_resp=1, found=1, entry.PFN0=20'h0ABCD at cycle 2; itlb_resp stays 0.
2. Tie and round-robin:
   - Stimulus: itlb_req and dtlb_req both high from reset, each re-raised immediately after its resp.
   - Required: grant order D, I, D, I; resps at cycles 2, 4, 6, 8.
3. Miss:
   - Stimulus: itlb_req with jtlb_found=0.
   - Required: itlb_resp=1 with itlb_found=0 at cycle 2.
4. Write versus lookup:
   - Stimulus: tlbw_req and dtlb_req rise together in IDLE.
   - Required: jtlb_we at cycle 1; fence_tlb and tlbw_done at cycle 2; D grant at cycle 3; dtlb_resp at cycle 5.
5. Write during LOOKUP:
   - Stimulus: tlbw_req raised in the LOOKUP cycle.
   - Required: resp delivered first; jtlb_we one cycle after the resp cycle; no grant in WRITE or FENCE.
6. Reset mid-LOOKUP:
   - Stimulus: rst asserted during LOOKUP.
   - Required: no resp pulse; state IDLE; prio_d=1; all outputs at reset values the cycle after rst.
